// File: rtl/layer_backprop_mac.sv
// Backward-pass error propagation: error_out = W^T * delta_in,
// one multiply-accumulate per clock, inner loop over next-layer neurons.
module layer_backprop_mac #(
   parameter int DATA_WIDTH       = 8,
   parameter int NS_IN_PREV_LAYER = 30,
   parameter int NS_IN_NEXT_LAYER = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic [NS_IN_NEXT_LAYER-1:0][NS_IN_PREV_LAYER-1:0][DATA_WIDTH-1:0] weights,
   input  logic [NS_IN_NEXT_LAYER-1:0][DATA_WIDTH-1:0] delta_in,
   output logic busy,
   output logic done,
   output logic [NS_IN_PREV_LAYER-1:0][DATA_WIDTH-1:0] error_out
);

   localparam int IW = (NS_IN_NEXT_LAYER > 1) ? $clog2(NS_IN_NEXT_LAYER) : 1;
   localparam int JW = (NS_IN_PREV_LAYER > 1) ? $clog2(NS_IN_PREV_LAYER) : 1;
   localparam int PW = 2 * DATA_WIDTH;
   // Headroom for N full-scale products, so the running sum never wraps
   localparam int AW = PW + $clog2(NS_IN_NEXT_LAYER) + 1;

   localparam logic [IW-1:0] I_LAST = IW'(NS_IN_NEXT_LAYER - 1);
   localparam logic [JW-1:0] J_LAST = JW'(NS_IN_PREV_LAYER - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] i;
   logic [JW-1:0] j;
   logic [AW-1:0] acc;
   logic [PW-1:0] prod;
   logic [AW-1:0] sum;

   always_comb begin
      prod = PW'(weights[i][j]) * PW'(delta_in[i]);
      sum  = acc + AW'(prod);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         i         <= '0;
         j         <= '0;
         acc       <= '0;
         error_out <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_MAC;
                  i     <= '0;
                  j     <= '0;
                  acc   <= '0;
               end
            end
            S_MAC: begin
               if (i == I_LAST) begin
                  // Column j complete: keep only the low bits, like the forward layer
                  error_out[j] <= sum[DATA_WIDTH-1:0];
                  acc          <= '0;
                  i            <= '0;
                  if (j == J_LAST) begin
                     state <= S_DONE;
                  end else begin
                     j <= j + JW'(1);
                  end
               end else begin
                  acc <= sum;
                  i   <= i + IW'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_layer_backprop_mac.sv
// Bench for layer_backprop_mac: directed table, handshake/reset sequences,
// degenerate N=1 and randomized default-size jobs against a reference model.
module tb_layer_backprop_mac;

   typedef logic [1:0][2:0][7:0] wa_t;
   typedef logic [1:0][7:0]      da_t;
   typedef logic [2:0][7:0]      ea_t;

   typedef struct {
      string nm;
      wa_t   w;
      da_t   d;
      ea_t   e;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic startA, busyA, doneA;
   wa_t  wA;
   da_t  dA;
   ea_t  eoA;

   logic                 startB, busyB, doneB;
   logic [0:0][3:0][7:0] wB;
   logic [0:0][7:0]      dB;
   logic [3:0][7:0]      eoB;

   logic                  startC, busyC, doneC;
   logic [9:0][29:0][7:0] wC;
   logic [9:0][7:0]       dC;
   logic [29:0][7:0]      eoC;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   layer_backprop_mac #(.DATA_WIDTH(8), .NS_IN_PREV_LAYER(3), .NS_IN_NEXT_LAYER(2)) dut_a (
      .clk(clk), .rst(rst), .start(startA), .weights(wA), .delta_in(dA),
      .busy(busyA), .done(doneA), .error_out(eoA));

   layer_backprop_mac #(.DATA_WIDTH(8), .NS_IN_PREV_LAYER(4), .NS_IN_NEXT_LAYER(1)) dut_b (
      .clk(clk), .rst(rst), .start(startB), .weights(wB), .delta_in(dB),
      .busy(busyB), .done(doneB), .error_out(eoB));

   layer_backprop_mac #(.DATA_WIDTH(8), .NS_IN_PREV_LAYER(30), .NS_IN_NEXT_LAYER(10)) dut_c (
      .clk(clk), .rst(rst), .start(startC), .weights(wC), .delta_in(dC),
      .busy(busyC), .done(doneC), .error_out(eoC));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   function automatic wa_t mk_w(int a0, int a1, int a2, int b0, int b1, int b2);
      wa_t w;
      w[0][0] = 8'(a0); w[0][1] = 8'(a1); w[0][2] = 8'(a2);
      w[1][0] = 8'(b0); w[1][1] = 8'(b1); w[1][2] = 8'(b2);
      return w;
   endfunction

   function automatic da_t mk_d(int d0, int d1);
      da_t d;
      d[0] = 8'(d0); d[1] = 8'(d1);
      return d;
   endfunction

   function automatic ea_t mk_e(int e0, int e1, int e2);
      ea_t e;
      e[0] = 8'(e0); e[1] = 8'(e1); e[2] = 8'(e2);
      return e;
   endfunction

   // Called one step after the accepting edge; lat = edges until done seen
   task automatic wait_done(input int sel, output int lat, output int bn);
      logic b, d;
      lat = -1;
      bn  = 0;
      for (int c = 0; c < 400; c++) begin
         case (sel)
            0: begin b = busyA; d = doneA; end
            1: begin b = busyB; d = doneB; end
            default: begin b = busyC; d = doneC; end
         endcase
         if (b) bn++;
         if (d) begin
            lat = c;
            break;
         end
         step();
      end
   endtask

   task automatic job_a(input wa_t w, input da_t d, output int lat, output int bn);
      wA = w;
      dA = d;
      startA = 1'b1;
      step();
      startA = 1'b0;
      wait_done(0, lat, bn);
   endtask

   vec_t vecs[4];
   int   lat, bn, ndone, t1, t2;
   ea_t  pre;

   initial begin
      rst = 1'b1;
      startA = 1'b0; startB = 1'b0; startC = 1'b0;
      wA = '0; dA = '0; wB = '0; dB = '0; wC = '0; dC = '0;

      vecs[0] = '{"basic", mk_w(1, 2, 3, 4, 5, 6), mk_d(1, 2), mk_e(9, 12, 15)};
      vecs[1] = '{"trunc", mk_w(255, 255, 255, 255, 255, 255), mk_d(255, 255), mk_e(2, 2, 2)};
      vecs[2] = '{"zero_delta", mk_w(1, 2, 3, 4, 5, 6), mk_d(0, 0), mk_e(0, 0, 0)};
      vecs[3] = '{"mixed", mk_w(10, 20, 30, 7, 8, 9), mk_d(3, 5), mk_e(65, 100, 135)};

      step();
      step();
      rst = 1'b0;
      chk("reset_busy", 256'(busyA), 256'(0));
      chk("reset_done", 256'(doneA), 256'(0));
      chk("reset_eo", 256'(eoA), 256'(0));

      foreach (vecs[k]) begin
         job_a(vecs[k].w, vecs[k].d, lat, bn);
         chk({vecs[k].nm, "_eo"}, 256'(eoA), 256'(vecs[k].e));
         chk({vecs[k].nm, "_lat"}, 256'(lat), 256'(6));
         chk({vecs[k].nm, "_busy_cycles"}, 256'(bn), 256'(7));
         step();
         chk({vecs[k].nm, "_done_width"}, 256'(doneA), 256'(0));
         chk({vecs[k].nm, "_idle"}, 256'(busyA), 256'(0));
      end

      // start pulses during MAC and DONE must not launch a second job
      wA = vecs[3].w;
      dA = vecs[3].d;
      startA = 1'b1;
      step();
      startA = 1'b0;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 2) startA = 1'b1;
         if (c == 3) startA = 1'b0;
         if (doneA) begin
            ndone++;
            startA = 1'b1;
            step();
            startA = 1'b0;
         end else begin
            step();
         end
      end
      chk("ignore_start_done_count", 256'(ndone), 256'(1));
      chk("ignore_start_idle", 256'(busyA), 256'(0));
      chk("ignore_start_eo", 256'(eoA), 256'(vecs[3].e));

      // start held high: second job accepted after IDLE is re-entered
      startA = 1'b1;
      t1 = -1;
      t2 = -1;
      for (int c = 0; c < 40; c++) begin
         step();
         if (doneA) begin
            if (t1 < 0) t1 = cyc;
            else if (t2 < 0) t2 = cyc;
         end
         if (t2 >= 0) break;
      end
      startA = 1'b0;
      chk("b2b_spacing", 256'(t2 - t1), 256'(8));
      for (int c = 0; c < 20 && busyA; c++) step();
      chk("b2b_settle", 256'(busyA), 256'(0));

      // reset on the third MAC cycle discards everything
      wA = vecs[0].w;
      dA = vecs[0].d;
      startA = 1'b1;
      step();
      startA = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_eo", 256'(eoA), 256'(0));
      chk("rst_mid_busy", 256'(busyA), 256'(0));
      ndone = 0;
      for (int c = 0; c < 10; c++) begin
         if (doneA) ndone++;
         step();
      end
      chk("rst_mid_no_done", 256'(ndone), 256'(0));
      job_a(vecs[0].w, vecs[0].d, lat, bn);
      chk("after_rst_eo", 256'(eoA), 256'(vecs[0].e));
      chk("after_rst_lat", 256'(lat), 256'(6));
      step();

      // degenerate single next-layer neuron
      wB[0][0] = 8'd1; wB[0][1] = 8'd2; wB[0][2] = 8'd3; wB[0][3] = 8'd4;
      dB[0] = 8'd3;
      startB = 1'b1;
      step();
      startB = 1'b0;
      wait_done(1, lat, bn);
      chk("n1_eo", 256'(eoB), 256'({8'd12, 8'd9, 8'd6, 8'd3}));
      chk("n1_lat", 256'(lat), 256'(4));
      chk("n1_busy_cycles", 256'(bn), 256'(5));
      step();

      // randomized default-size jobs against an arithmetic model
      for (int job = 0; job < 20; job++) begin
         logic [29:0][7:0] exp;
         for (int a = 0; a < 10; a++) begin
            dC[a] = 8'($urandom_range(0, 255));
            for (int b = 0; b < 30; b++) wC[a][b] = 8'($urandom_range(0, 255));
         end
         for (int b = 0; b < 30; b++) begin
            int s;
            s = 0;
            for (int a = 0; a < 10; a++) s += int'(wC[a][b]) * int'(dC[a]);
            exp[b] = 8'(s % 256);
         end
         startC = 1'b1;
         step();
         startC = 1'b0;
         wait_done(2, lat, bn);
         chk($sformatf("rand%0d_eo", job), 256'(eoC), 256'(exp));
         chk($sformatf("rand%0d_lat", job), 256'(lat), 256'(300));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
